fetch_stall_unit: RTL and testbench

Fetch-side responder to the pipeline stall signal. It owns the PC and the IF/ID pipeline register. When `stall_ip` is high it freezes fetch and decode and tells the ID/EX register to load a bubble. When a branch resolves taken it redirects the PC and squashes the wrong-path fetch. It sits between instruction memory and the decode stage, and consumes the stall output of the hazard controller. It also keeps stall statistics and a deadlock watchdog for the bench and debug.

---
 rtl/fetch_stall_unit_pkg.sv | 16 +
 rtl/sat_counter.sv | 24 ++
 rtl/fetch_stall_unit.sv | 95 +++++++++
 tb/tb_fetch_stall_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stall_unit_pkg.sv
// rtl/fetch_stall_unit_pkg.sv - shared constants and types for the fetch stall unit
package fetch_stall_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    FLUSH
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stall_unit.sv
// rtl/fetch_stall_unit.sv - PC and IF/ID owner reacting to stall and taken-branch
module fetch_stall_unit
  import fetch_stall_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        branch_taken_ip,
  input  logic [31:0] branch_target_ip,
  input  logic [31:0] imem_instr_ip,
  output logic [31:0] imem_addr_op,
  output logic [31:0] ID_instr_op,
  output logic [31:0] ID_pc_op,
  output logic        ID_valid_op,
  output logic        EX_bubble_op,
  output logic [31:0] stall_cycles_op,
  output logic        deadlock_op
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  fetch_state_t state, next_state;
  logic [31:0]  pc_q;
  logic         deadlock_q;
  logic         stall_count_en;
  logic         stall_at_max;
  logic         run_at_max;
  logic [RUN_W-1:0] run_count;

  // A branch in the same cycle as a stall wins, so that stall is not counted.
  assign stall_count_en = stall_ip && !branch_taken_ip;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = RUN;
    EX_bubble_op = 1'b0;
    if (branch_taken_ip)  next_state = FLUSH;
    else if (stall_ip)    next_state = HOLD;
    if (!reset) EX_bubble_op = stall_ip || branch_taken_ip || (state == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= align_pc(RESET_PC);
      ID_instr_op <= NOP_INSTR;
      ID_pc_op    <= '0;
      ID_valid_op <= 1'b0;
    end else if (branch_taken_ip) begin
      pc_q        <= align_pc(branch_target_ip);
      ID_instr_op <= NOP_INSTR;
      ID_pc_op    <= '0;
      ID_valid_op <= 1'b0;
    end else if (!stall_ip) begin
      pc_q        <= pc_q + 32'd4;
      ID_instr_op <= imem_instr_ip;
      ID_pc_op    <= pc_q;
      ID_valid_op <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(32)) u_stall_total (
    .clk    (clk),
    .reset  (reset),
    .inc    (stall_count_en && !stall_at_max),
    .clr    (1'b0),
    .count  (stall_cycles_op),
    .at_max (stall_at_max)
  );

  sat_counter #(.WIDTH(RUN_W), .MAX(RUN_W'(MAX_STALL))) u_stall_run (
    .clk    (clk),
    .reset  (reset),
    .inc    (stall_count_en),
    .clr    (!stall_count_en),
    .count  (run_count),
    .at_max (run_at_max)
  );

  // Report the trip as soon as the run counter hits the limit, then latch it.
  always_ff @(posedge clk) begin
    if (reset) deadlock_q <= 1'b0;
    else       deadlock_q <= deadlock_q || run_at_max;
  end

  assign deadlock_op  = deadlock_q || run_at_max;
  assign imem_addr_op = pc_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// tb/tb_fetch_stall_unit.sv - directed self-checking bench for fetch_stall_unit
module tb_fetch_stall_unit;

  logic        clk;
  logic        reset;
  logic        stall_ip;
  logic        branch_taken_ip;
  logic [31:0] branch_target_ip;
  logic [31:0] imem_instr_ip;
  logic [31:0] imem_addr_op;
  logic [31:0] ID_instr_op;
  logic [31:0] ID_pc_op;
  logic        ID_valid_op;
  logic        EX_bubble_op;
  logic [31:0] stall_cycles_op;
  logic        deadlock_op;

  int tests_run;
  int tests_failed;

  fetch_stall_unit #(.RESET_PC(32'h100), .MAX_STALL(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_ip         (stall_ip),
    .branch_taken_ip  (branch_taken_ip),
    .branch_target_ip (branch_target_ip),
    .imem_instr_ip    (imem_instr_ip),
    .imem_addr_op     (imem_addr_op),
    .ID_instr_op      (ID_instr_op),
    .ID_pc_op         (ID_pc_op),
    .ID_valid_op      (ID_valid_op),
    .EX_bubble_op     (EX_bubble_op),
    .stall_cycles_op  (stall_cycles_op),
    .deadlock_op      (deadlock_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address a reads as 0xA000_0000 ^ a.
  assign imem_instr_ip = 32'hA000_0000 ^ imem_addr_op;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_ip = 1'b0; branch_taken_ip = 1'b0; branch_target_ip = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_ip = 1'b1; branch_taken_ip = 1'b0;
    #1;
    tests_run++;
    if (EX_bubble_op !== 1'b0) begin tests_failed++; $display("FAIL reset_bubble: got %b want 0", EX_bubble_op); end
    tick();
    tests_run++;
    if (imem_addr_op !== 32'h100) begin tests_failed++; $display("FAIL reset_pc: got %h want 00000100", imem_addr_op); end
    tests_run++;
    if (ID_instr_op !== 32'h13) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000013", ID_instr_op); end
    tests_run++;
    if (ID_pc_op !== 32'h0 || ID_valid_op !== 1'b0) begin tests_failed++; $display("FAIL reset_id: got pc %h valid %b want 0/0", ID_pc_op, ID_valid_op); end
    tests_run++;
    if (stall_cycles_op !== 32'h0 || deadlock_op !== 1'b0) begin tests_failed++; $display("FAIL reset_counters: got %h/%b want 0/0", stall_cycles_op, deadlock_op); end
    stall_ip = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      #1;
      tests_run++;
      if (EX_bubble_op !== 1'b0) begin tests_failed++; $display("FAIL run_bubble%0d: got %b want 0", i, EX_bubble_op); end
      tick();
      tests_run++;
      if (ID_pc_op !== exp_pc || ID_valid_op !== 1'b1) begin tests_failed++; $display("FAIL run_id_pc%0d: got %h/%b want %h/1", i, ID_pc_op, ID_valid_op, exp_pc); end
      tests_run++;
      if (ID_instr_op !== (32'hA000_0000 ^ exp_pc)) begin tests_failed++; $display("FAIL run_instr%0d: got %h want %h", i, ID_instr_op, 32'hA000_0000 ^ exp_pc); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall_ip = 1'b1;
    #1;
    tests_run++;
    if (EX_bubble_op !== 1'b1) begin tests_failed++; $display("FAIL stall_bubble: got %b want 1", EX_bubble_op); end
    tick();
    tests_run++;
    if (imem_addr_op !== 32'h108) begin tests_failed++; $display("FAIL stall_pc: got %h want 00000108", imem_addr_op); end
    tests_run++;
    if (ID_pc_op !== 32'h104 || ID_instr_op !== 32'hA000_0104) begin tests_failed++; $display("FAIL stall_id: got %h/%h want 00000104/a0000104", ID_pc_op, ID_instr_op); end
    tests_run++;
    if (stall_cycles_op !== 32'd1) begin tests_failed++; $display("FAIL stall_count: got %0d want 1", stall_cycles_op); end
    stall_ip = 1'b0;
    #1;
    tests_run++;
    if (EX_bubble_op !== 1'b0) begin tests_failed++; $display("FAIL stall_release_bubble: got %b want 0", EX_bubble_op); end
    tick();
    tests_run++;
    if (ID_pc_op !== 32'h108 || imem_addr_op !== 32'h10C) begin tests_failed++; $display("FAIL stall_release: got %h/%h want 00000108/0000010c", ID_pc_op, imem_addr_op); end
  endtask

  task automatic test_branch_with_stall();
    branch_taken_ip = 1'b1; stall_ip = 1'b1; branch_target_ip = 32'h200;
    #1;
    tests_run++;
    if (EX_bubble_op !== 1'b1) begin tests_failed++; $display("FAIL br_bubble1: got %b want 1", EX_bubble_op); end
    tick();
    branch_taken_ip = 1'b0; stall_ip = 1'b0;
    tests_run++;
    if (imem_addr_op !== 32'h200) begin tests_failed++; $display("FAIL br_pc: got %h want 00000200", imem_addr_op); end
    tests_run++;
    if (ID_valid_op !== 1'b0 || ID_instr_op !== 32'h13) begin tests_failed++; $display("FAIL br_squash: got %b/%h want 0/00000013", ID_valid_op, ID_instr_op); end
    tests_run++;
    if (stall_cycles_op !== 32'd1) begin tests_failed++; $display("FAIL br_stall_count: got %0d want 1", stall_cycles_op); end
    #1;
    tests_run++;
    if (EX_bubble_op !== 1'b1) begin tests_failed++; $display("FAIL br_bubble2: got %b want 1", EX_bubble_op); end
    tick();
    tests_run++;
    if (ID_pc_op !== 32'h200 || ID_valid_op !== 1'b1 || ID_instr_op !== 32'hA000_0200) begin tests_failed++; $display("FAIL br_target_id: got %h/%b/%h want 00000200/1/a0000200", ID_pc_op, ID_valid_op, ID_instr_op); end
    tests_run++;
    if (EX_bubble_op !== 1'b0) begin tests_failed++; $display("FAIL br_bubble3: got %b want 0", EX_bubble_op); end
  endtask

  task automatic test_deadlock();
    do_reset();
    stall_ip = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    tests_run++;
    if (deadlock_op !== 1'b0 || stall_cycles_op !== 32'd15) begin tests_failed++; $display("FAIL dl_15: got %b/%0d want 0/15", deadlock_op, stall_cycles_op); end
    tick();
    tests_run++;
    if (deadlock_op !== 1'b1 || stall_cycles_op !== 32'd16) begin tests_failed++; $display("FAIL dl_16: got %b/%0d want 1/16", deadlock_op, stall_cycles_op); end
    stall_ip = 1'b0;
    tick();
    tick();
    tests_run++;
    if (deadlock_op !== 1'b1) begin tests_failed++; $display("FAIL dl_sticky: got %b want 1", deadlock_op); end
    tests_run++;
    if (stall_cycles_op !== 32'd16) begin tests_failed++; $display("FAIL dl_count_hold: got %0d want 16", stall_cycles_op); end
  endtask

  task automatic test_reset_mid_stall();
    stall_ip = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    #1;
    tests_run++;
    if (EX_bubble_op !== 1'b0) begin tests_failed++; $display("FAIL rms_bubble: got %b want 0", EX_bubble_op); end
    tick();
    tests_run++;
    if (imem_addr_op !== 32'h100 || ID_instr_op !== 32'h13) begin tests_failed++; $display("FAIL rms_regs: got %h/%h want 00000100/00000013", imem_addr_op, ID_instr_op); end
    tests_run++;
    if (stall_cycles_op !== 32'd0 || deadlock_op !== 1'b0) begin tests_failed++; $display("FAIL rms_counters: got %0d/%b want 0/0", stall_cycles_op, deadlock_op); end
    reset = 1'b0; stall_ip = 1'b0;
  endtask

  task automatic test_wrap_and_align();
    do_reset();
    branch_taken_ip = 1'b1; branch_target_ip = 32'hFFFF_FFFC;
    tick();
    branch_taken_ip = 1'b0;
    tests_run++;
    if (imem_addr_op !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr_op); end
    tick();
    tests_run++;
    if (imem_addr_op !== 32'h0 || ID_pc_op !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc: got %h/%h want 00000000/fffffffc", imem_addr_op, ID_pc_op); end
    branch_taken_ip = 1'b1; branch_target_ip = 32'h203;
    tick();
    branch_taken_ip = 1'b0;
    tests_run++;
    if (imem_addr_op !== 32'h200) begin tests_failed++; $display("FAIL align_pc: got %h want 00000200", imem_addr_op); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; stall_ip = 1'b0; branch_taken_ip = 1'b0; branch_target_ip = '0;
    tick();
    test_reset();
    test_free_run();
    test_stall();
    test_branch_with_stall();
    test_deadlock();
    test_reset_mid_stall();
    test_wrap_and_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
